// File: rtl/period_counter_pkg.sv
// rtl/period_counter_pkg.sv - shared sizing defaults and period lookup for the period counter
package period_counter_pkg;

  localparam int unsigned BASE_DIV = 100;
  localparam int unsigned Q_W      = 4;
  localparam int unsigned DIV_W    = 14;

  // Step period in clock cycles: base doubled once per switch position.
  function automatic logic [DIV_W-1:0] period_of(input logic [2:0] sw,
                                                 input int unsigned base = BASE_DIV);
    logic [DIV_W-1:0] base_w;
    base_w = DIV_W'(base);
    return base_w << sw;
  endfunction

endpackage

// File: rtl/period_counter_tick_gen.sv
// rtl/period_counter_tick_gen.sv - prescaler producing a one-cycle tick every selected period
module period_counter_tick_gen
  import period_counter_pkg::*;
#(
  parameter int unsigned BASE_DIV_P = BASE_DIV
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [2:0] sw_i,
  output logic       tick_o
);

  logic [DIV_W-1:0] period;
  logic [DIV_W-1:0] last;
  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;

  assign period = period_of(sw_i, BASE_DIV_P);
  assign last   = period - DIV_W'(1);

  // A shrinking period that leaves the count beyond the new terminal value
  // restarts the prescaler silently instead of running out the old period.
  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    tick_o    = 1'b0;
    if (div_cnt_q == last) begin
      div_cnt_d = '0;
      tick_o    = 1'b1;
    end else if (div_cnt_q > last) begin
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/period_counter.sv
// rtl/period_counter.sv - free-running counter stepping at a switch-selected prescaled rate
module period_counter
  import period_counter_pkg::*;
#(
  parameter int unsigned BASE_DIV_P = BASE_DIV,
  parameter int unsigned Q_W_P      = Q_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       sw,
  output logic             en,
  output logic [Q_W_P-1:0] q
);

  logic             tick;
  logic             en_q;
  logic             en_d;
  logic [Q_W_P-1:0] q_q;
  logic [Q_W_P-1:0] q_d;

  period_counter_tick_gen #(
    .BASE_DIV_P (BASE_DIV_P)
  ) u_tick_gen (
    .clk_i   (clk),
    .reset_i (reset),
    .sw_i    (sw),
    .tick_o  (tick)
  );

  // en is registered alongside q so it marks the first cycle the new value is visible.
  always_comb begin
    en_d = tick;
    q_d  = q_q;
    if (tick) begin
      q_d = q_q + Q_W_P'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q <= 1'b0;
      q_q  <= '0;
    end else begin
      en_q <= en_d;
      q_q  <= q_d;
    end
  end

  assign en = en_q;
  assign q  = q_q;

endmodule

// File: tb/tb_period_counter.sv
// tb/tb_period_counter.sv - directed self-checking bench for period_counter
module tb_period_counter;

  logic       clk;
  logic       reset;
  logic [2:0] sw;
  logic       en;
  logic [3:0] q;

  int errors;
  int checks;
  logic       prev_en;
  logic [3:0] prev_q;

  period_counter dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw),
    .en    (en),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Advances one cycle and checks en is never back-to-back and q moves only with en.
  task automatic mon_cyc();
    prev_en = en;
    prev_q  = q;
    cyc();
    check("en_not_consecutive", {31'd0, en & prev_en}, 32'd0);
    check("q_change_only_on_en", {31'd0, (q !== prev_q) & ~en}, 32'd0);
  endtask

  task automatic do_reset(input logic [2:0] sel);
    reset = 1'b1;
    sw    = sel;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    sw     = 3'd0;

    // 1: reset state and first-step latency at sw=0
    cyc();
    check("reset_q", {28'd0, q}, 32'd0);
    check("reset_en", {31'd0, en}, 32'd0);
    reset = 1'b0;
    repeat (99) cyc();
    check("pre_first_step_q", {28'd0, q}, 32'd0);
    check("pre_first_step_en", {31'd0, en}, 32'd0);
    cyc();
    check("first_step_q", {28'd0, q}, 32'd1);
    check("first_step_en", {31'd0, en}, 32'd1);

    // 2 + 6: steady stepping every 100 cycles through the 15 -> 0 wrap
    for (int k = 101; k <= 1650; k++) begin
      mon_cyc();
      check("sw0_en", {31'd0, en}, (k % 100 == 0) ? 32'd1 : 32'd0);
      check("sw0_q", {28'd0, q}, 32'((k / 100) % 16));
      if (k == 1500) check("reach_15", {28'd0, q}, 32'd15);
      if (k == 1600) begin
        check("wrap_q", {28'd0, q}, 32'd0);
        check("wrap_en", {31'd0, en}, 32'd1);
      end
    end

    // 3: sw=1 gives 200-cycle period
    do_reset(3'd1);
    repeat (199) cyc();
    check("sw1_pre_q", {28'd0, q}, 32'd0);
    check("sw1_pre_en", {31'd0, en}, 32'd0);
    cyc();
    check("sw1_step1_q", {28'd0, q}, 32'd1);
    check("sw1_step1_en", {31'd0, en}, 32'd1);
    repeat (199) cyc();
    check("sw1_mid_q", {28'd0, q}, 32'd1);
    check("sw1_mid_en", {31'd0, en}, 32'd0);
    cyc();
    check("sw1_step2_q", {28'd0, q}, 32'd2);
    check("sw1_step2_en", {31'd0, en}, 32'd1);

    // 3: sw=7 gives 12800-cycle period
    do_reset(3'd7);
    repeat (12799) cyc();
    check("sw7_pre_q", {28'd0, q}, 32'd0);
    check("sw7_pre_en", {31'd0, en}, 32'd0);
    cyc();
    check("sw7_step_q", {28'd0, q}, 32'd1);
    check("sw7_step_en", {31'd0, en}, 32'd1);

    // 4: shrink from period 800 to 100 at div_cnt=500 restarts without a step
    do_reset(3'd3);
    repeat (500) cyc();
    sw = 3'd0;
    mon_cyc();
    check("shrink_no_en", {31'd0, en}, 32'd0);
    check("shrink_q", {28'd0, q}, 32'd0);
    for (int k = 1; k <= 99; k++) mon_cyc();
    check("shrink_pre_q", {28'd0, q}, 32'd0);
    check("shrink_pre_en", {31'd0, en}, 32'd0);
    mon_cyc();
    check("shrink_step_q", {28'd0, q}, 32'd1);
    check("shrink_step_en", {31'd0, en}, 32'd1);

    // 5: reset mid-period with q=9
    do_reset(3'd0);
    repeat (900) cyc();
    check("q9_reached", {28'd0, q}, 32'd9);
    repeat (50) cyc();
    check("q9_mid", {28'd0, q}, 32'd9);
    reset = 1'b1;
    cyc();
    check("midreset_q", {28'd0, q}, 32'd0);
    check("midreset_en", {31'd0, en}, 32'd0);
    reset = 1'b0;
    repeat (99) cyc();
    check("restart_pre_q", {28'd0, q}, 32'd0);
    check("restart_pre_en", {31'd0, en}, 32'd0);
    cyc();
    check("restart_step_q", {28'd0, q}, 32'd1);
    check("restart_step_en", {31'd0, en}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
